dom1_skinny_rnd_ctrl: RTL and testbench
=======================================

DOM1_SKINNY_RND_CTRL -- requirements
Module: dom1_skinny_rnd_ctrl

Interface
REQ-001 SHALL have parameter NR, default 40, meaning the number of Skinny rounds per encryption (legal range 1..63).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all flops update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an encryption; it is sampled only in IDLE.
REQ-005 SHALL have port rnd_valid, input, 1 bit: the fresh-randomness source has a valid 48-bit word on r.
REQ-006 SHALL have port rnd_ready, output, 1 bit: the current r word is consumed this cycle.
REQ-007 SHALL have port en, output, 4 bits: one-hot S-box stage enables for the masked round datapath.
REQ-008 SHALL have port st_ld, output, 1 bit: load the plaintext shares into the state register.
REQ-009 SHALL have port st_we, output, 1 bit: write the round-output shares into the state register.
REQ-010 SHALL have port tk_upd, output, 1 bit: advance the tweakey schedule and round constant by one round.
REQ-011 SHALL have port rnd_cnt, output, 6 bits: index of the current round, starting at 0.
REQ-012 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-013 SHALL have port done, output, 1 bit: single-cycle pulse when the ciphertext shares are valid in the state register.

Function
REQ-014 The FSM SHALL have the states IDLE, P0, P1, P2, P3, WB and DONE.
REQ-015 In IDLE with start=1, st_ld SHALL be 1 combinationally, rnd_cnt SHALL clear to 0, and the next state SHALL be P0.
REQ-016 In state Pk (k=0..3), en SHALL equal 1<<k when the phase is allowed to fire, and 0 otherwise.
REQ-017 In state Pk, rnd_ready SHALL equal en[k].
REQ-018 In state Pk, the FSM SHALL advance to the next phase (P0->P1->P2->P3->WB) only when the phase fires.
REQ-019 In WB, st_we and tk_upd SHALL both be 1 for exactly one cycle, and en SHALL be 0.
REQ-020 From WB with rnd_cnt<NR-1, rnd_cnt SHALL increment and the next state SHALL be P0.
REQ-021 From WB with rnd_cnt=NR-1, the next state SHALL be DONE.
REQ-022 In DONE, done SHALL be 1 for one cycle, the next state SHALL be IDLE, and rnd_cnt SHALL hold NR-1.
REQ-023 en SHALL never have more than one bit set, and SHALL be 0 outside P0..P3.
REQ-024 st_ld, st_we and en SHALL be mutually exclusive in every cycle.
REQ-025 When rnd_valid is always 1, latency SHALL be 5*NR+1 cycles from the start-accept edge to the done cycle (done is high in cycle 5*NR+1).
REQ-026 start while busy SHALL be ignored (no restart, no queuing).
REQ-027 start asserted in the DONE cycle SHALL be ignored; it is accepted in the following IDLE cycle if still high.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 On rst=1, regardless of clk, the FSM SHALL enter IDLE and rnd_cnt SHALL become 0.
REQ-030 While rst=1, en, st_ld, st_we, tk_upd, rnd_ready, busy and done SHALL all be 0.
REQ-031 Reset mid-encryption SHALL abort immediately, with no st_we/done pulse afterwards.
REQ-032 After reset mid-encryption, the next start SHALL begin a fresh run from round 0.

Configuration
REQ-033 The block SHALL use the macro DOM1_RND_STALL_EN.
REQ-034 With DOM1_RND_STALL_EN defined, phase Pk SHALL fire only when rnd_valid=1; otherwise the FSM holds Pk with en=0 and rnd_ready=0, and no datapath state changes.
REQ-035 Without DOM1_RND_STALL_EN, rnd_valid SHALL be ignored, every Pk SHALL fire unconditionally, and latency SHALL always be 5*NR+1 cycles.

Verification
REQ-036 Bench scenario: NR=40, rnd_valid=1, start pulse -> st_ld once; en sequence 1,2,4,8 then st_we/tk_upd, repeated 40 times; done at cycle 201; rnd_cnt ends at 39; en never multi-hot.
REQ-037 Bench scenario: DOM1_RND_STALL_EN defined, rnd_valid=0 for 3 cycles during P2 of round 5 -> en=0 and rnd_ready=0 for 3 cycles, then en=4b0100; done at cycle 204.
REQ-038 Bench scenario: rst asserted during P1 of round 12 -> outputs 0 asynchronously, no done; a new start yields a full 201-cycle run from rnd_cnt=0.
REQ-039 Bench scenario: start held high continuously -> back-to-back runs with one IDLE cycle between done and the next st_ld; start is ignored while busy=1.
REQ-040 Bench scenario: NR=1 -> P0..P3, WB, DONE; done at cycle 6; tk_upd pulses exactly once.
REQ-041 Bench scenario: macro undefined, rnd_valid=0 throughout -> run completes in 5*NR+1 cycles, with rnd_ready pulsing 4*NR times.

Source files
------------

// File: rtl/dom1_skinny_rnd_ctrl.sv
// Round controller for a DOM-1 masked Skinny core: 4 S-box phases + write-back per round, done 5*NR+1 cycles after start.
// Backpressure: with DOM1_RND_STALL_EN defined a phase waits for rnd_valid; otherwise randomness is consumed unconditionally.
module dom1_skinny_rnd_ctrl #(
  parameter int NR = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rnd_valid,
  output logic       rnd_ready,
  output logic [3:0] en,
  output logic       st_ld,
  output logic       st_we,
  output logic       tk_upd,
  output logic [5:0] rnd_cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    WB   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [5:0] LAST_RND = 6'(NR - 1);

  state_t state;
  logic   fire;

`ifdef DOM1_RND_STALL_EN
  assign fire = rnd_valid;
`else
  logic unused_rnd_valid;
  assign unused_rnd_valid = rnd_valid;
  assign fire = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rnd_cnt <= 6'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= P0;
          rnd_cnt <= 6'd0;
        end
        P0: if (fire) state <= P1;
        P1: if (fire) state <= P2;
        P2: if (fire) state <= P3;
        P3: if (fire) state <= WB;
        WB: begin
          if (rnd_cnt == LAST_RND) begin
            state <= DONE;
          end else begin
            rnd_cnt <= rnd_cnt + 6'd1;
            state   <= P0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state directly; rst gating keeps st_ld low even if start is held through reset.
  always_comb begin
    en     = 4'b0000;
    st_ld  = 1'b0;
    st_we  = 1'b0;
    tk_upd = 1'b0;
    done   = 1'b0;
    busy   = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: st_ld = start;
        P0:   en = fire ? 4'b0001 : 4'b0000;
        P1:   en = fire ? 4'b0010 : 4'b0000;
        P2:   en = fire ? 4'b0100 : 4'b0000;
        P3:   en = fire ? 4'b1000 : 4'b0000;
        WB: begin
          st_we  = 1'b1;
          tk_upd = 1'b1;
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

  // Exactly one phase is active in any Pk, so the word is consumed iff that phase fires.
  assign rnd_ready = |en;

endmodule

// File: tb/tb_dom1_skinny_rnd_ctrl.sv
// Bench for dom1_skinny_rnd_ctrl: NR=40 and NR=1 instances driven from a per-cycle expectation queue.
module tb_dom1_skinny_rnd_ctrl;

  typedef struct packed {
    logic       st_ld;
    logic [3:0] en;
    logic       st_we;
    logic       tk_upd;
    logic       done;
    logic       rnd_ready;
    logic       busy;
    logic [5:0] rnd_cnt;
  } obs_t;

  typedef struct packed {
    logic start;
    logic rv;
    obs_t exp;
  } cyc_t;

  typedef struct {
    bit   nr1;
    int   runs;
    logic hold;
    int   sr;
    int   sp;
    int   sl;
    logic rvd;
    int   lat;
  } scen_t;

  logic clk, rst, rnd_valid;
  logic start40, start1;
  logic rdy40, st_ld40, st_we40, tk40, busy40, done40;
  logic rdy1, st_ld1, st_we1, tk1, busy1, done1;
  logic [3:0] en40, en1;
  logic [5:0] cnt40, cnt1;
  obs_t o40, o1;

  int total = 0;
  int bad = 0;
  cyc_t sbq[$];
  logic [5:0] last40 = 6'd0;
  logic [5:0] last1 = 6'd0;

  dom1_skinny_rnd_ctrl #(.NR(40)) u40 (
    .clk(clk), .rst(rst), .start(start40), .rnd_valid(rnd_valid), .rnd_ready(rdy40),
    .en(en40), .st_ld(st_ld40), .st_we(st_we40), .tk_upd(tk40), .rnd_cnt(cnt40),
    .busy(busy40), .done(done40)
  );

  dom1_skinny_rnd_ctrl #(.NR(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .rnd_valid(rnd_valid), .rnd_ready(rdy1),
    .en(en1), .st_ld(st_ld1), .st_we(st_we1), .tk_upd(tk1), .rnd_cnt(cnt1),
    .busy(busy1), .done(done1)
  );

  assign o40 = {st_ld40, en40, st_we40, tk40, done40, rdy40, busy40, cnt40};
  assign o1  = {st_ld1, en1, st_we1, tk1, done1, rdy1, busy1, cnt1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic s, input logic rv, input logic ld, input logic [3:0] e,
                      input logic we, input logic dn, input logic bz, input logic [5:0] cnt);
    cyc_t c;
    c.start = s;
    c.rv    = rv;
    c.exp   = {ld, e, we, we, dn, |e, bz, cnt};
    sbq.push_back(c);
  endtask

  // One complete encryption as seen cycle by cycle, starting with the start-accept cycle.
  task automatic gen_run(input int nr, input logic [5:0] prev, input logic hold,
                         input int sr, input int sp, input int sl, input logic rvd);
    push(1'b1, rvd, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, prev);
    for (int r = 0; r < nr; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (r == sr && k == sp)
          for (int s = 0; s < sl; s++) push(hold, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 6'(r));
        push(hold, rvd, 1'b0, 4'(1 << k), 1'b0, 1'b0, 1'b1, 6'(r));
      end
      push(hold, rvd, 1'b0, 4'b0, 1'b1, 1'b0, 1'b1, 6'(r));
    end
    push(hold, rvd, 1'b0, 4'b0, 1'b0, 1'b1, 1'b1, 6'(nr - 1));
  endtask

  task automatic run_q(input bit sel1, input int nr, input int lat, input int limit);
    cyc_t c;
    obs_t o;
    int n = 0;
    int cyc = 0;
    int tk = 0;
    int rd = 0;
    while (sbq.size() != 0 && (limit < 0 || n < limit)) begin
      c = sbq.pop_front();
      @(posedge clk);
      #1;
      start40   = sel1 ? 1'b0 : c.start;
      start1    = sel1 ? c.start : 1'b0;
      rnd_valid = c.rv;
      @(negedge clk);
      o = sel1 ? o1 : o40;
      check("cycle_obs", 32'(o), 32'(c.exp));
      check("en_onehot0", 32'($onehot0(o.en)), 32'd1);
      check("ld_we_en_excl", 32'(int'(o.st_ld) + int'(o.st_we) + int'(|o.en) <= 1), 32'd1);
      if (o.st_ld) begin
        cyc = 0;
        tk  = 0;
        rd  = 0;
      end else begin
        cyc++;
      end
      tk += int'(o.tk_upd);
      rd += int'(o.rnd_ready);
      if (o.done) begin
        check("latency", 32'(cyc), 32'(lat));
        check("tk_upd_count", 32'(tk), 32'(nr));
        check("rnd_ready_count", 32'(rd), 32'(4 * nr));
      end
      n++;
    end
    sbq.delete();
  endtask

  scen_t tbl[4];

  initial begin
    tbl[0] = '{nr1: 1'b0, runs: 1, hold: 1'b0, sr: -1, sp: 0, sl: 0, rvd: 1'b1, lat: 201};
`ifdef DOM1_RND_STALL_EN
    tbl[1] = '{nr1: 1'b0, runs: 1, hold: 1'b0, sr: 5, sp: 2, sl: 3, rvd: 1'b1, lat: 204};
`else
    tbl[1] = '{nr1: 1'b0, runs: 1, hold: 1'b0, sr: -1, sp: 0, sl: 0, rvd: 1'b0, lat: 201};
`endif
    tbl[2] = '{nr1: 1'b1, runs: 1, hold: 1'b0, sr: -1, sp: 0, sl: 0, rvd: 1'b1, lat: 6};
    tbl[3] = '{nr1: 1'b0, runs: 2, hold: 1'b1, sr: -1, sp: 0, sl: 0, rvd: 1'b1, lat: 201};

    rst = 1'b1;
    start40 = 1'b1;
    start1 = 1'b1;
    rnd_valid = 1'b1;
    #3;
    check("reset_outputs_nr40", 32'(o40), 32'd0);
    check("reset_outputs_nr1", 32'(o1), 32'd0);
    start40 = 1'b0;
    start1 = 1'b0;
    #20;
    rst = 1'b0;

    foreach (tbl[i]) begin
      int nr;
      logic [5:0] prev;
      nr   = tbl[i].nr1 ? 1 : 40;
      prev = tbl[i].nr1 ? last1 : last40;
      for (int r = 0; r < tbl[i].runs; r++) begin
        gen_run(nr, prev, tbl[i].hold, tbl[i].sr, tbl[i].sp, tbl[i].sl, tbl[i].rvd);
        prev = 6'(nr - 1);
      end
      push(1'b0, tbl[i].rvd, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, prev);
      run_q(tbl[i].nr1, nr, tbl[i].lat, -1);
      if (tbl[i].nr1) last1 = prev;
      else last40 = prev;
    end

    // Abort during P1 of round 12: cycle 1 + 12*5 + 1 = 62 is the last one compared.
    gen_run(40, last40, 1'b0, -1, 0, 0, 1'b1);
    run_q(1'b0, 40, 201, 63);
    #2;
    rst = 1'b1;
    #1;
    check("async_abort_outputs", 32'(o40), 32'd0);
    @(posedge clk);
    #1;
    check("held_reset_outputs", 32'(o40), 32'd0);
    #2;
    rst = 1'b0;
    last40 = 6'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      start40 = 1'b0;
      @(negedge clk);
      check("no_done_after_abort", 32'(done40), 32'd0);
      check("no_we_after_abort", 32'(st_we40), 32'd0);
      check("idle_after_abort", 32'(busy40), 32'd0);
    end
    gen_run(40, last40, 1'b0, -1, 0, 0, 1'b1);
    push(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 6'd39);
    run_q(1'b0, 40, 201, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
